// File: rtl/updi_phy_ctrl.sv
// updi_phy_ctrl: byte-level UPDI PHY controller in front of the UART/UPDI bridge.
// It turns sequencer bytes into 12-bit UPDI frames on uart_tx, turns frames seen
// on uart_rx back into bytes, and drives the bridge mode select.
// Frame: start(0), 8 data bits LSB first, even parity, 2 stop bits (1).
//
// Ports
//   clk, rst_n              system clock, async active-low reset
//   tx_data/valid/ready     byte to send (valid/ready handshake)
//   rx_req, rx_len          pulse in IDLE: receive rx_len bytes (0 = no-op)
//   rx_data/valid/err       received byte strobe, err on parity/stop1 fault
//   rx_timeout              pulse when no start bit arrives in time
//   break_req               pulse in IDLE: issue a BREAK
//   busy                    high in every state except IDLE
//   mode                    bridge mode select (registered)
//   uart_tx, uart_rx        bridge tx input / bridge rx output

package updi_phy_pkg;
  typedef enum logic [1:0] {
    UPDI_BRIDGE_MODE_IDLE  = 2'd0,
    UPDI_BRIDGE_MODE_TX    = 2'd1,
    UPDI_BRIDGE_MODE_RX    = 2'd2,
    UPDI_BRIDGE_MODE_BREAK = 2'd3
  } updi_bridge_mode;
endpackage

// state     | meaning
// S_IDLE    | waiting for break_req / tx_valid / rx_req
// S_BREAK   | driving BREAK for BREAK_BITS bit times
// S_TX_BITS | shifting out the 12 frame bits
// S_GUARD   | idle-high guard after the last TX frame
// S_RX_WAIT | waiting for an armed start-bit edge, timeout running
// S_RX_BITS | sampling start, data, parity and stop1 mid-bit
module updi_phy_ctrl
  import updi_phy_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100,
  parameter int BREAK_BITS   = 12,
  parameter int GUARD_BITS   = 2,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  input  logic            rx_req,
  input  logic [7:0]      rx_len,
  output logic [7:0]      rx_data,
  output logic            rx_valid,
  output logic            rx_err,
  output logic            rx_timeout,
  input  logic            break_req,
  output logic            busy,
  output updi_bridge_mode mode,
  output logic            uart_tx,
  input  logic            uart_rx
);

  localparam int BRK_CYC = BREAK_BITS * CLKS_PER_BIT;
  localparam int GRD_CYC = GUARD_BITS * CLKS_PER_BIT;
  localparam int TO_CYC  = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TMR_MAX = (BRK_CYC > GRD_CYC) ? BRK_CYC : GRD_CYC;
  localparam int TW      = $clog2(TMR_MAX + 1);
  localparam int TOW     = $clog2(TO_CYC + 1);

  localparam logic [TW-1:0]  BIT_LD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0]  HALF_LD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0]  BRK_LD  = TW'(BRK_CYC - 1);
  localparam logic [TW-1:0]  GRD_LD  = TW'(GRD_CYC - 1);
  localparam logic [TOW-1:0] TO_LD   = TOW'(TO_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_BREAK, S_TX_BITS, S_GUARD, S_RX_WAIT, S_RX_BITS
  } state_t;

  state_t          state, state_nxt;
  updi_bridge_mode mode_nxt;

  logic [TW-1:0]   tmr;
  logic [TOW-1:0]  to_cnt;
  logic [3:0]      bit_cnt;
  logic [11:0]     tx_sh;
  logic [7:0]      rx_sh;
  logic            rx_par;
  logic [7:0]      rx_left;
  logic            rx_meta, rx_s;
  logic            armed;
  logic            ready_en;   // keeps tx_ready low until the first cycle after reset
  logic            tmr_tc;
  logic            take_tx, take_rx, take_brk, rx_start;

  assign tmr_tc = (tmr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      mode  <= UPDI_BRIDGE_MODE_IDLE;
    end else begin
      state <= state_nxt;
      mode  <= mode_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    take_tx   = 1'b0;
    take_rx   = 1'b0;
    take_brk  = 1'b0;
    rx_start  = 1'b0;
    case (state)
      S_IDLE: begin
        if (break_req) begin
          take_brk  = 1'b1;
          state_nxt = S_BREAK;
        end else if (tx_valid && ready_en) begin
          take_tx   = 1'b1;
          state_nxt = S_TX_BITS;
        end else if (rx_req && (rx_len != 8'd0)) begin
          take_rx   = 1'b1;
          state_nxt = S_RX_WAIT;
        end
      end
      S_BREAK: if (tmr_tc) state_nxt = S_IDLE;
      S_TX_BITS: begin
        if (tmr_tc && (bit_cnt == 4'd11)) begin
          if (tx_valid) take_tx = 1'b1;
          else          state_nxt = S_GUARD;
        end
      end
      S_GUARD: begin
        if (tx_valid) begin
          take_tx   = 1'b1;
          state_nxt = S_TX_BITS;
        end else if (rx_req && (rx_len != 8'd0)) begin
          take_rx   = 1'b1;
          state_nxt = S_RX_WAIT;
        end else if (tmr_tc) begin
          state_nxt = S_IDLE;
        end
      end
      S_RX_WAIT: begin
        if (to_cnt == '0) begin
          state_nxt = S_IDLE;
        end else if (armed && !rx_s) begin
          rx_start  = 1'b1;
          state_nxt = S_RX_BITS;
        end
      end
      S_RX_BITS: begin
        if (tmr_tc) begin
          if ((bit_cnt == 4'd0) && rx_s)
            state_nxt = S_RX_WAIT;
          else if (bit_cnt == 4'd10)
            state_nxt = (rx_left == 8'd1) ? S_IDLE : S_RX_WAIT;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != S_IDLE);
    tx_ready = take_tx;
    uart_tx  = (state == S_TX_BITS) ? tx_sh[0] : 1'b1;
    case (state_nxt)
      S_BREAK:              mode_nxt = UPDI_BRIDGE_MODE_BREAK;
      S_TX_BITS, S_GUARD:   mode_nxt = UPDI_BRIDGE_MODE_TX;
      S_RX_WAIT, S_RX_BITS: mode_nxt = UPDI_BRIDGE_MODE_RX;
      default:              mode_nxt = UPDI_BRIDGE_MODE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr        <= '0;
      to_cnt     <= '0;
      bit_cnt    <= 4'd0;
      tx_sh      <= '0;
      rx_sh      <= 8'd0;
      rx_par     <= 1'b0;
      rx_left    <= 8'd0;
      rx_meta    <= 1'b0;
      rx_s       <= 1'b0;
      armed      <= 1'b0;
      ready_en   <= 1'b0;
      rx_data    <= 8'd0;
      rx_valid   <= 1'b0;
      rx_err     <= 1'b0;
      rx_timeout <= 1'b0;
    end else begin
      ready_en   <= 1'b1;
      rx_meta    <= uart_rx;
      rx_s       <= rx_meta;
      rx_valid   <= 1'b0;
      rx_err     <= 1'b0;
      rx_timeout <= 1'b0;
      if (!tmr_tc) tmr <= tmr - TW'(1);

      if (take_tx) begin
        tx_sh   <= {2'b11, ^tx_data, tx_data, 1'b0};
        tmr     <= BIT_LD;
        bit_cnt <= 4'd0;
      end else if (take_brk) begin
        tmr <= BRK_LD;
      end else if (take_rx) begin
        rx_left <= rx_len;
        to_cnt  <= TO_LD;
        armed   <= 1'b0;
      end else begin
        case (state)
          S_TX_BITS: begin
            if (tmr_tc) begin
              if (bit_cnt == 4'd11) begin
                tmr <= GRD_LD;
              end else begin
                tx_sh   <= {1'b1, tx_sh[11:1]};
                bit_cnt <= bit_cnt + 4'd1;
                tmr     <= BIT_LD;
              end
            end
          end
          S_RX_WAIT: begin
            // arming needs rx high first: the bridge drives 0 outside RX mode
            armed <= armed | rx_s;
            if (to_cnt == '0) rx_timeout <= 1'b1;
            else              to_cnt <= to_cnt - TOW'(1);
            if (rx_start) begin
              tmr     <= HALF_LD;
              bit_cnt <= 4'd0;
            end
          end
          S_RX_BITS: begin
            if (tmr_tc) begin
              tmr     <= BIT_LD;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd0) begin
                if (rx_s) armed <= 1'b1;   // start-bit glitch; timeout keeps its count
              end else if (bit_cnt <= 4'd8) begin
                rx_sh <= {rx_s, rx_sh[7:1]};
              end else if (bit_cnt == 4'd9) begin
                rx_par <= rx_s;
              end else begin
                rx_valid <= 1'b1;
                rx_data  <= rx_sh;
                rx_err   <= (^{rx_sh, rx_par}) | ~rx_s;
                rx_left  <= rx_left - 8'd1;
                to_cnt   <= TO_LD;
                armed    <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_updi_phy_ctrl.sv
// Bench for updi_phy_ctrl with CLKS_PER_BIT=4, BREAK_BITS=12, GUARD_BITS=2,
// TIMEOUT_BITS=64. Expected TX line cycles and RX bytes go into queues as the
// stimulus is driven; monitors pop and compare as the DUT produces them.
module tb_updi_phy_ctrl;
  import updi_phy_pkg::*;

  localparam int CPB = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic            rx_req;
  logic [7:0]      rx_len;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            rx_err;
  logic            rx_timeout;
  logic            break_req;
  logic            busy;
  updi_bridge_mode mode;
  logic            uart_tx;
  logic            uart_rx;

  always #5 clk = ~clk;

  updi_phy_ctrl #(
    .CLKS_PER_BIT(CPB), .BREAK_BITS(12), .GUARD_BITS(2), .TIMEOUT_BITS(64)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_req(rx_req), .rx_len(rx_len),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err), .rx_timeout(rx_timeout),
    .break_req(break_req), .busy(busy), .mode(mode),
    .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       e;
  } rx_exp_t;

  int      n_chk = 0;
  int      n_pass = 0;
  int      n_tmo = 0;
  bit      tx_mon_en = 1'b1;
  logic    tx_q[$];
  rx_exp_t rx_q[$];
  rx_exp_t rx_e;
  logic    tx_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  // expected uart_tx per TX-mode cycle: 12 frame bits x CPB, plus guard if last
  task automatic push_frame(input logic [7:0] d, input bit guard);
    logic [11:0] f;
    f = {2'b11, ^d, d, 1'b0};
    for (int i = 0; i < 12; i++)
      for (int c = 0; c < CPB; c++) tx_q.push_back(f[i]);
    if (guard)
      for (int c = 0; c < 2 * CPB; c++) tx_q.push_back(1'b1);
  endtask

  always @(negedge clk) begin
    if (rst_n && tx_mon_en && mode == UPDI_BRIDGE_MODE_TX) begin
      if (tx_q.size() == 0) chk("tx_q_depth", tx_q.size(), 1);
      else begin
        tx_e = tx_q.pop_front();
        chk("tx_line", uart_tx, tx_e);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        if (rx_q.size() == 0) chk("rx_q_depth", rx_q.size(), 1);
        else begin
          rx_e = rx_q.pop_front();
          chk("rx_data", rx_data, rx_e.d);
          chk("rx_err", rx_err, rx_e.e);
        end
      end else if (rx_err) begin
        chk("rx_err_without_valid", rx_err, 0);
      end
      if (rx_timeout) n_tmo++;
    end
  end

  task automatic start_tx(input logic [7:0] d, input bit guard);
    tx_data  = d;
    tx_valid = 1'b1;
    push_frame(d, guard);
  endtask

  task automatic wait_take(input bit drop);
    int n;
    n = 0;
    #1;
    while (!tx_ready && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("tx_ready_seen", tx_ready, 1);
    @(posedge clk);
    @(negedge clk);
    if (drop) tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (mode != UPDI_BRIDGE_MODE_IDLE && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, mode, UPDI_BRIDGE_MODE_IDLE);
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic par, input logic stop1, input logic exp_err);
    logic [11:0] f;
    f = {1'b1, stop1, par, d, 1'b0};
    rx_q.push_back({d, exp_err});
    for (int i = 0; i < 12; i++) begin
      uart_rx = f[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
  endtask

  task automatic rx_request(input logic [7:0] len);
    rx_req = 1'b1;
    rx_len = len;
    @(negedge clk);
    rx_req = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tx_data = 8'h00; tx_valid = 1'b0; rx_req = 1'b0; rx_len = 8'd0;
    break_req = 1'b0; uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_mode", mode, UPDI_BRIDGE_MODE_IDLE);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_err", rx_err, 0);
    chk("rst_rx_timeout", rx_timeout, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // single byte, then guard, then idle
    start_tx(8'h55, 1'b1);
    wait_take(1'b1);
    wait_idle("tx55_idle");
    chk("tx55_q_empty", tx_q.size(), 0);
    repeat (2) @(negedge clk);

    // back-to-back frames with no guard in between
    start_tx(8'h55, 1'b0);
    wait_take(1'b0);
    start_tx(8'hC3, 1'b1);
    wait_take(1'b1);
    wait_idle("b2b_idle");
    chk("b2b_q_empty", tx_q.size(), 0);
    repeat (2) @(negedge clk);

    // break wins over a simultaneous tx_valid, which is served afterwards
    break_req = 1'b1;
    start_tx(8'h5A, 1'b1);
    @(negedge clk);
    break_req = 1'b0;
    chk("brk_mode", mode, UPDI_BRIDGE_MODE_BREAK);
    chk("brk_busy", busy, 1);
    chk("brk_uart_tx", uart_tx, 1);
    n = 0;
    while (mode == UPDI_BRIDGE_MODE_BREAK && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("brk_len", n, 48);
    chk("brk_then_idle", mode, UPDI_BRIDGE_MODE_IDLE);
    wait_take(1'b1);
    wait_idle("brk_tx_idle");
    chk("brk_tx_q_empty", tx_q.size(), 0);

    // rx_len of zero does nothing
    rx_request(8'd0);
    chk("rxlen0_mode", mode, UPDI_BRIDGE_MODE_IDLE);
    chk("rxlen0_busy", busy, 0);

    // two good frames
    rx_request(8'd2);
    chk("rx2_mode", mode, UPDI_BRIDGE_MODE_RX);
    uart_rx = 1'b1;
    repeat (8) @(negedge clk);
    rx_frame(8'h01, 1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    rx_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    wait_idle("rx2_idle");
    chk("rx2_q_empty", rx_q.size(), 0);
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);

    // bad parity, then stop1 low
    rx_request(8'd2);
    uart_rx = 1'b1;
    repeat (8) @(negedge clk);
    rx_frame(8'h03, 1'b1, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    rx_frame(8'h10, 1'b1, 1'b0, 1'b1);
    wait_idle("rxerr_idle");
    chk("rxerr_q_empty", rx_q.size(), 0);
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);

    // one-cycle low glitch before a real frame
    rx_request(8'd1);
    uart_rx = 1'b1;
    repeat (8) @(negedge clk);
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (12) @(negedge clk);
    chk("glitch_still_rx", mode, UPDI_BRIDGE_MODE_RX);
    rx_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    wait_idle("glitch_idle");
    chk("glitch_q_empty", rx_q.size(), 0);
    repeat (4) @(negedge clk);

    // timeout with rx held high
    rx_request(8'd1);
    chk("tmo_mode", mode, UPDI_BRIDGE_MODE_RX);
    n = 0;
    while (!rx_timeout && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", n, 256);
    chk("tmo_mode_idle", mode, UPDI_BRIDGE_MODE_IDLE);
    @(negedge clk);
    chk("tmo_one_cycle", rx_timeout, 0);
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);

    // asynchronous reset in the middle of a frame
    tx_mon_en = 1'b0;
    tx_data = 8'h00;
    tx_valid = 1'b1;
    wait_take(1'b1);
    repeat (10) @(negedge clk);
    chk("mid_uart_tx_low", uart_tx, 0);
    chk("mid_mode_tx", mode, UPDI_BRIDGE_MODE_TX);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_uart_tx", uart_tx, 1);
    chk("arst_mode", mode, UPDI_BRIDGE_MODE_IDLE);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tx_mon_en = 1'b1;
    repeat (3) @(negedge clk);

    // clean frame after the reset
    start_tx(8'h0F, 1'b1);
    wait_take(1'b1);
    wait_idle("post_rst_idle");
    chk("post_rst_q_empty", tx_q.size(), 0);

    chk("timeout_pulses", n_tmo, 1);
    chk("rx_q_final", rx_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
